// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU and PC-select codes, FSM state encoding, trap causes.
package mips_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type functs
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADDU = 4'b0100;
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_INV  = 4'b1111;

  // Next-PC source select
  localparam logic [2:0] PC_PLUS4  = 3'b000;
  localparam logic [2:0] PC_JUMP   = 3'b001;
  localparam logic [2:0] PC_JR     = 3'b010;
  localparam logic [2:0] PC_BRANCH = 3'b011;
  localparam logic [2:0] PC_TRAP   = 3'b100;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC   = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB     = 3'b100,
    ST_TRAP   = 3'b101
  } state_t;

  // Instruction classes as seen by the sequencer
  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_IMM   = 3'd1,
    CLS_J     = 3'd2,
    CLS_JR    = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_BNE   = 3'd5,
    CLS_LOAD  = 3'd6,
    CLS_STORE = 3'd7
  } iclass_t;

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational IR decode: class, ALU op, shift amount, store byte mask
// and an illegal-instruction flag.
module instr_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int SHAMT_W = 5
) (
  input  logic [31:0]        ir,
  output logic [2:0]         cls,
  output logic [3:0]         alu_ctrl,
  output logic [SHAMT_W-1:0] shamt,
  output logic [3:0]         st_mask,
  output logic               illegal
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = ir[31:26];
  assign fn = ir[5:0];

  // Opcode/funct table; unknown encodings raise illegal
  always_comb begin
    cls      = CLS_R;
    alu_ctrl = ALU_INV;
    shamt    = '0;
    st_mask  = 4'b0000;
    illegal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_ADDU: alu_ctrl = ALU_ADDU;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_SUBU: alu_ctrl = ALU_SUBU;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_XOR:  alu_ctrl = ALU_XOR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_SLL: begin
            alu_ctrl = ALU_SLL;
            shamt    = SHAMT_W'(ir[10:6]);
          end
          FN_SRL: begin
            alu_ctrl = ALU_SRL;
            shamt    = SHAMT_W'(ir[10:6]);
          end
          FN_SRA: begin
            alu_ctrl = ALU_SRA;
            shamt    = SHAMT_W'(ir[10:6]);
          end
          FN_JR:   cls = CLS_JR;
          default: illegal = 1'b1;
        endcase
      end
      OP_J:   cls = CLS_J;
      // Branch compare is a wrap-around subtract; only alu_zero matters
      OP_BEQ: begin cls = CLS_BEQ; alu_ctrl = ALU_SUBU; end
      OP_BNE: begin cls = CLS_BNE; alu_ctrl = ALU_SUBU; end
      OP_ADDI:  begin cls = CLS_IMM; alu_ctrl = ALU_ADD;  end
      OP_ADDIU: begin cls = CLS_IMM; alu_ctrl = ALU_ADDU; end
      OP_SLTI:  begin cls = CLS_IMM; alu_ctrl = ALU_SLT;  end
      OP_ANDI:  begin cls = CLS_IMM; alu_ctrl = ALU_AND;  end
      OP_ORI:   begin cls = CLS_IMM; alu_ctrl = ALU_OR;   end
      // LUI: the datapath presents the pre-shifted immediate; ALU ORs it with $0
      OP_LUI:   begin cls = CLS_IMM; alu_ctrl = ALU_OR;   end
      OP_LW: begin cls = CLS_LOAD;  alu_ctrl = ALU_ADD; end
      OP_SW: begin cls = CLS_STORE; alu_ctrl = ALU_ADD; st_mask = 4'b1111; end
      OP_SH: begin cls = CLS_STORE; alu_ctrl = ALU_ADD; st_mask = 4'b0011; end
      OP_SB: begin cls = CLS_STORE; alu_ctrl = ALU_ADD; st_mask = 4'b0001; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer with the
// instruction register, unified-memory req/ready handshake and bus watchdog.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter bit TRAP_EN     = 1'b1,
  parameter int SHAMT_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic               mem_req,
  output logic               mem_is_instr,
  output logic [3:0]         data_mem_wren,
  output logic [31:0]        instr,
  output logic               ir_wren,
  output logic               pc_wren,
  output logic [2:0]         pc_control,
  output logic               reg_file_wren,
  output logic               reg_file_dmux_select,
  output logic               reg_file_rmux_select,
  output logic               alu_mux_select,
  output logic [3:0]         alu_control,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic               exc,
  output logic [1:0]         exc_cause,
  output logic [2:0]         state
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t             st_q, st_d;
  logic [31:0]        ir_q;
  logic [CNT_W-1:0]   wd_cnt;
  logic [1:0]         cause_q, cause_d;
  logic               timeout;

  logic [2:0]         dec_cls;
  logic [3:0]         dec_alu;
  logic [SHAMT_W-1:0] dec_shamt;
  logic [3:0]         dec_mask;
  logic               dec_ill;

  instr_decoder #(.SHAMT_W(SHAMT_W)) u_dec (
    .ir       (ir_q),
    .cls      (dec_cls),
    .alu_ctrl (dec_alu),
    .shamt    (dec_shamt),
    .st_mask  (dec_mask),
    .illegal  (dec_ill)
  );

  // Watchdog fires on the cycle whose stall would bring the count to MEM_TIMEOUT;
  // a same-cycle mem_ready is excluded so the completed access wins
  assign timeout = (MEM_TIMEOUT != 0) && (st_q == ST_FETCH || st_q == ST_MEM) &&
                   !mem_ready && (wd_cnt == TMO_LAST);

  // State, IR and trap-cause registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_FETCH;
      ir_q    <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      st_q    <= st_d;
      cause_q <= cause_d;
      if (ir_wren) ir_q <= mem_rdata;
    end
  end

  // Stall counter: cleared on every state change, counts unanswered requests
  always_ff @(posedge clk) begin
    if (rst || st_d != st_q)
      wd_cnt <= '0;
    else if (MEM_TIMEOUT != 0 && mem_req && !mem_ready)
      wd_cnt <= wd_cnt + 1'b1;
  end

  // Next-state and output decode; everything is held at 0 while rst is high
  always_comb begin
    st_d                 = st_q;
    cause_d              = cause_q;
    mem_req              = 1'b0;
    mem_is_instr         = 1'b0;
    data_mem_wren        = 4'b0000;
    instr                = '0;
    ir_wren              = 1'b0;
    pc_wren              = 1'b0;
    pc_control           = PC_PLUS4;
    reg_file_wren        = 1'b0;
    reg_file_dmux_select = 1'b0;
    reg_file_rmux_select = 1'b0;
    alu_mux_select       = 1'b0;
    alu_control          = 4'b0000;
    alu_shamt            = '0;
    exc                  = 1'b0;
    exc_cause            = 2'b00;
    state                = 3'b000;
    if (!rst) begin
      instr     = ir_q;
      exc_cause = cause_q;
      state     = st_q;
      case (st_q)
        ST_FETCH: begin
          mem_req      = 1'b1;
          mem_is_instr = 1'b1;
          if (mem_ready) begin
            ir_wren = 1'b1;
            pc_wren = 1'b1;
            st_d    = ST_DECODE;
          end else if (timeout) begin
            st_d    = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        ST_DECODE: begin
          if (dec_ill) begin
            if (TRAP_EN) begin
              st_d    = ST_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end else begin
              st_d = ST_FETCH;
            end
          end else if (dec_cls == CLS_J) begin
            pc_wren    = 1'b1;
            pc_control = PC_JUMP;
            st_d       = ST_FETCH;
          end else if (dec_cls == CLS_JR) begin
            pc_wren    = 1'b1;
            pc_control = PC_JR;
            st_d       = ST_FETCH;
          end else begin
            st_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_control    = dec_alu;
          alu_shamt      = dec_shamt;
          alu_mux_select = (dec_cls != CLS_R);
          case (dec_cls)
            CLS_BEQ, CLS_BNE: begin
              if (alu_zero == (dec_cls == CLS_BEQ)) begin
                pc_wren    = 1'b1;
                pc_control = PC_BRANCH;
              end
              st_d = ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: st_d = ST_MEM;
            default:             st_d = ST_WB;
          endcase
        end
        ST_MEM: begin
          mem_req       = 1'b1;
          data_mem_wren = dec_mask;
          if (mem_ready) begin
            st_d = (dec_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
          end else if (timeout) begin
            st_d    = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        ST_WB: begin
          reg_file_wren        = 1'b1;
          reg_file_dmux_select = (dec_cls != CLS_LOAD);
          reg_file_rmux_select = (dec_cls == CLS_R);
          st_d                 = ST_FETCH;
        end
        ST_TRAP: begin
          pc_wren    = 1'b1;
          pc_control = PC_TRAP;
          exc        = 1'b1;
          st_d       = ST_FETCH;
        end
        default: st_d = ST_FETCH;
      endcase
    end
  end

endmodule
